video_mem_ctrl: RTL
===================

Name: video_mem_ctrl

Overview:
Parametrised video memory controller. It owns the VRAM and OAM arrays behind the CPU DataBus and serves a dedicated PPU read port. It enforces the PPU-mode access lockouts and contains a built-in OAM DMA engine. It is the successor to the fixed-map whizgraphics memory: region bases and sizes are generic, and arbitration, open-bus and DMA behaviour are new.

Parameters:
DATA_W, 8, data width of all ports and arrays
ADDR_W, 16, CPU/DMA address width
VRAM_BASE, 16'h8000, first CPU address of VRAM
VRAM_SIZE, 8192, VRAM depth in bytes (power of two)
OAM_BASE, 16'hFE00, first CPU address of OAM
OAM_SIZE, 160, OAM depth in bytes; also the DMA transfer length
OPEN_BUS, 8'hFF, value returned on a locked CPU read

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_we  in  1  CPU write strobe, one cycle per access
cpu_re  in  1  CPU read strobe, one cycle per access
cpu_hit  out  1  combinational: cpu_addr decodes to VRAM or OAM
cpu_rdata  out  DATA_W  CPU read data
cpu_rvalid  out  1  cpu_rdata valid
ppu_mode  in  2  current PPU mode (0 HBlank, 1 VBlank, 2 OAM scan, 3 transfer)
ppu_vram_addr  in  $clog2(VRAM_SIZE)  PPU VRAM index
ppu_vram_re  in  1  PPU VRAM read strobe
ppu_vram_rdata  out  DATA_W  PPU VRAM read data, registered
ppu_oam_addr  in  $clog2(OAM_SIZE)  PPU OAM index
ppu_oam_re  in  1  PPU OAM read strobe
ppu_oam_rdata  out  DATA_W  PPU OAM read data, registered
dma_start  in  1  pulse: start OAM DMA
dma_src_page  in  8  source high byte, sampled on dma_start
dma_busy  out  1  DMA in progress
dma_req  out  1  DMA source read request
dma_addr  out  ADDR_W  {src_page, idx}
dma_ack  in  1  source data valid on dma_data; completes the request
dma_data  in  DATA_W  source read data

Behaviour:
- Reset: cpu_rdata=0, cpu_rvalid=0, ppu_*_rdata=0, dma_busy=0, dma_req=0, dma_addr=0, FSM=IDLE. Array contents are not cleared.
- Decode: VRAM if VRAM_BASE <= addr < VRAM_BASE+VRAM_SIZE; OAM if OAM_BASE <= addr < OAM_BASE+OAM_SIZE. Index = addr - base.
- Miss (cpu_hit=0): write dropped, no cpu_rvalid, cpu_rdata holds its value.
- Lock rules:
  - VRAM locked when ppu_mode==3.
  - OAM locked when ppu_mode is 2 or 3, or when dma_busy.
- CPU read: cpu_rvalid is high exactly 1 cycle after a hit cpu_re. Data is the array byte, or OPEN_BUS if locked in the strobe cycle.
- CPU write: takes effect at the strobe edge, only if not locked. A locked write is silently dropped.
- cpu_we and cpu_re together: the write is performed and the read is ignored (no cpu_rvalid).
- PPU ports: never locked, 1-cycle latency. rdata holds its value when re=0. Read-before-write: a same-cycle write to the same index returns the old byte.
- DMA FSM states IDLE, REQ, WRITE:
  - IDLE: on dma_start, latch page, idx=0, busy=1, go to REQ.
  - REQ: dma_req=1 and dma_addr={page, idx} are held until dma_ack. On dma_ack, capture dma_data and go to WRITE.
  - WRITE: OAM[idx] <= data (overrides lock and any CPU write). If idx==OAM_SIZE-1, go to IDLE with busy=0 next cycle; else idx++ and go to REQ.
  - Minimum 2 cycles per byte.
- dma_start while busy restarts at idx 0 with the new page. A pending request is abandoned and a dma_ack arriving in that same cycle is ignored.
- dma_ack in IDLE or WRITE is ignored.
- rst mid-DMA aborts immediately. Bytes already written remain.

Decomposition:
- video_types package gains: ppu_mode_t enum (HBLANK, VBLANK, OAM_SCAN, TRANSFER), dma_state_t enum, default region constants (VRAM_BASE, VRAM_SIZE, OAM_BASE, OAM_SIZE).
- One sub-module, vm_sp_ram: one write port plus two registered read ports, parametrised on depth and width. Instantiated twice, for VRAM and OAM.
- Decode, lock and DMA logic stay in the top.

Test Plan:
- mode=0: write 8'hA5 to 16'h8000 and 8'h3C to 16'hFE9F, read both back -> cpu_rvalid 1 cycle after each re, data A5 and 3C.
- mode=3: write 8'h11 to 16'h8010, read it -> rdata FF; then mode=0 read -> the original pre-existing byte, not 11.
- mode=2: read 16'hFE00 -> FF, read 16'h8000 -> real data. Access 16'hFEA0 -> cpu_hit=0, no rvalid.
- dma_start, page 8'hC1, source returns byte i^8'h5A with a random 0-3 cycle ack delay -> dma_addr steps C100..C19F, busy for the whole transfer; afterwards OAM[i]==i^5A for all 160 bytes. CPU OAM reads during DMA -> FF.
- dma_start again at idx 50 with page 8'hC2 -> transfer restarts at C200 and all 160 bytes come from C2xx.
- rst asserted mid-DMA at idx 20 -> next cycle busy=0, req=0, rvalid=0. OAM[0..19] keep the DMA data.

Source files
------------

// File: rtl/video_mem_ctrl_pkg.sv
// Shared types and default region map for the video memory controller.
//   ppu_mode_t  : PPU mode encoding as presented on the ppu_mode port
//   dma_state_t : OAM DMA engine states
//   DEF_*       : default parameter values for the controller
//   in_region   : half-open address range test used by the CPU decoder
package video_mem_ctrl_pkg;

    typedef enum logic [1:0] {
        HBLANK   = 2'd0,
        VBLANK   = 2'd1,
        OAM_SCAN = 2'd2,
        TRANSFER = 2'd3
    } ppu_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WRITE = 2'd2
    } dma_state_t;

    localparam int unsigned DEF_DATA_W    = 8;
    localparam int unsigned DEF_ADDR_W    = 16;
    localparam logic [15:0] DEF_VRAM_BASE = 16'h8000;
    localparam int unsigned DEF_VRAM_SIZE = 8192;
    localparam logic [15:0] DEF_OAM_BASE  = 16'hFE00;
    localparam int unsigned DEF_OAM_SIZE  = 160;
    localparam logic [7:0]  DEF_OPEN_BUS  = 8'hFF;

    // True when base <= addr < base + size (32-bit so base+size cannot wrap).
    function automatic logic in_region(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] size);
        return (addr >= base) && (addr < base + size);
    endfunction

endpackage

// File: rtl/video_mem_ctrl_if.sv
// CPU DataBus between a CPU-side master and the video memory controller.
//   cpu_addr/cpu_wdata/cpu_we/cpu_re : driven by the master, one-cycle strobes
//   cpu_hit    : combinational decode result from the controller
//   cpu_rdata  : read data, valid when cpu_rvalid is high
//   cpu_rvalid : pulses one cycle after an accepted read strobe
interface video_mem_ctrl_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
);
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_we;
    logic              cpu_re;
    logic              cpu_hit;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;

    modport master (
        output cpu_addr, cpu_wdata, cpu_we, cpu_re,
        input  cpu_hit, cpu_rdata, cpu_rvalid
    );

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_we, cpu_re,
        output cpu_hit, cpu_rdata, cpu_rvalid
    );
endinterface

// File: rtl/video_mem_ctrl_sp_ram.sv
// Byte array with one write port and two independent registered read ports.
//   clk, rst          : clock; rst clears only the read registers, not the array
//   we/waddr/wdata    : write port, takes effect on the rising edge
//   a_re/a_addr/a_rdata, b_re/b_addr/b_rdata :
//                       read ports, 1-cycle latency, rdata holds while re=0,
//                       a same-edge write to the same index returns the old byte
module vm_sp_ram #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             a_re,
    input  logic [AW-1:0]    a_addr,
    output logic [WIDTH-1:0] a_rdata,
    input  logic             b_re,
    input  logic [AW-1:0]    b_addr,
    output logic [WIDTH-1:0] b_rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_rdata <= '0;
            b_rdata <= '0;
        end else begin
            if (a_re) begin
                a_rdata <= mem[a_addr];
            end
            if (b_re) begin
                b_rdata <= mem[b_addr];
            end
        end
    end
endmodule

// File: rtl/video_mem_ctrl.sv
// Video memory controller: VRAM and OAM behind the CPU DataBus, a dedicated
// PPU read port per array, PPU-mode access lockouts and an OAM DMA engine.
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   bus             : CPU DataBus (slave side)
//   ppu_mode        : 0 HBlank, 1 VBlank, 2 OAM scan, 3 transfer
//   ppu_vram_*      : PPU VRAM read port, 1-cycle latency, never locked
//   ppu_oam_*       : PPU OAM read port, 1-cycle latency, never locked
//   dma_start/dma_src_page : start (or restart) an OAM DMA from page<<8
//   dma_busy/dma_req/dma_addr/dma_ack/dma_data : DMA status and source handshake
module video_mem_ctrl
    import video_mem_ctrl_pkg::*;
#(
    parameter int unsigned       DATA_W    = DEF_DATA_W,
    parameter int unsigned       ADDR_W    = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] VRAM_BASE = DEF_VRAM_BASE,
    parameter int unsigned       VRAM_SIZE = DEF_VRAM_SIZE,
    parameter logic [ADDR_W-1:0] OAM_BASE  = DEF_OAM_BASE,
    parameter int unsigned       OAM_SIZE  = DEF_OAM_SIZE,
    parameter logic [DATA_W-1:0] OPEN_BUS  = DEF_OPEN_BUS
) (
    input  logic                         clk,
    input  logic                         rst,
    video_mem_ctrl_if.slave              bus,
    input  logic [1:0]                   ppu_mode,
    input  logic [$clog2(VRAM_SIZE)-1:0] ppu_vram_addr,
    input  logic                         ppu_vram_re,
    output logic [DATA_W-1:0]            ppu_vram_rdata,
    input  logic [$clog2(OAM_SIZE)-1:0]  ppu_oam_addr,
    input  logic                         ppu_oam_re,
    output logic [DATA_W-1:0]            ppu_oam_rdata,
    input  logic                         dma_start,
    input  logic [7:0]                   dma_src_page,
    output logic                         dma_busy,
    output logic                         dma_req,
    output logic [ADDR_W-1:0]            dma_addr,
    input  logic                         dma_ack,
    input  logic [DATA_W-1:0]            dma_data
);
    localparam int unsigned VRAM_AW   = $clog2(VRAM_SIZE);
    localparam int unsigned OAM_AW    = $clog2(OAM_SIZE);
    localparam int unsigned PAGE_LO_W = ADDR_W - 8;
    localparam logic [OAM_AW-1:0] OAM_LAST = OAM_AW'(OAM_SIZE - 1);

    // ---------------- CPU decode and lockout ----------------
    ppu_mode_t         mode;
    logic              vram_hit, oam_hit;
    logic              vram_lock, oam_lock;
    logic [VRAM_AW-1:0] vram_idx;
    logic [OAM_AW-1:0]  oam_idx;
    logic              cpu_rd;

    always_comb begin
        mode      = ppu_mode_t'(ppu_mode);
        vram_hit  = in_region(32'(bus.cpu_addr), 32'(VRAM_BASE), 32'(VRAM_SIZE));
        oam_hit   = in_region(32'(bus.cpu_addr), 32'(OAM_BASE), 32'(OAM_SIZE));
        vram_idx  = VRAM_AW'(bus.cpu_addr - VRAM_BASE);
        oam_idx   = OAM_AW'(bus.cpu_addr - OAM_BASE);
        vram_lock = (mode == TRANSFER);
        oam_lock  = (mode == OAM_SCAN) || (mode == TRANSFER) || dma_busy;
        // A combined write+read strobe performs only the write.
        cpu_rd    = bus.cpu_re && !bus.cpu_we;
    end

    assign bus.cpu_hit = vram_hit || oam_hit;

    logic vram_cpu_we, oam_cpu_we;
    logic vram_a_re, oam_a_re;
    logic rd_fire;

    always_comb begin
        vram_cpu_we = vram_hit && bus.cpu_we && !vram_lock;
        oam_cpu_we  = oam_hit && bus.cpu_we && !oam_lock;
        vram_a_re   = vram_hit && cpu_rd && !vram_lock;
        oam_a_re    = oam_hit && cpu_rd && !oam_lock;
        rd_fire     = (vram_hit || oam_hit) && cpu_rd;
    end

    // ---------------- CPU read return ----------------
    // The array read registers only move on an unlocked read and the
    // select/lock flags only on an accepted read, so the muxed cpu_rdata
    // holds its value across misses and idle cycles.
    logic rd_valid, rd_oam, rd_locked;
    logic [DATA_W-1:0] vram_a_rdata, oam_a_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid  <= 1'b0;
            rd_oam    <= 1'b0;
            rd_locked <= 1'b0;
        end else begin
            rd_valid <= rd_fire;
            if (rd_fire) begin
                rd_oam    <= oam_hit;
                rd_locked <= oam_hit ? oam_lock : vram_lock;
            end
        end
    end

    assign bus.cpu_rvalid = rd_valid;
    assign bus.cpu_rdata  = rd_locked ? OPEN_BUS : (rd_oam ? oam_a_rdata : vram_a_rdata);

    // ---------------- OAM DMA engine ----------------
    dma_state_t        state, state_d;
    logic [7:0]        page, page_d;
    logic [OAM_AW-1:0] idx, idx_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            page   <= '0;
            idx    <= '0;
            data_q <= '0;
        end else begin
            state  <= state_d;
            page   <= page_d;
            idx    <= idx_d;
            data_q <= data_d;
        end
    end

    always_comb begin
        state_d = state;
        page_d  = page;
        idx_d   = idx;
        data_d  = data_q;
        // A start pulse wins over everything, including an ack in the same cycle.
        if (dma_start) begin
            state_d = REQ;
            page_d  = dma_src_page;
            idx_d   = '0;
        end else begin
            case (state)
                IDLE: begin
                end
                REQ: begin
                    if (dma_ack) begin
                        data_d  = dma_data;
                        state_d = WRITE;
                    end
                end
                WRITE: begin
                    if (idx == OAM_LAST) begin
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx + OAM_AW'(1);
                        state_d = REQ;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign dma_busy = (state != IDLE);
    assign dma_req  = (state == REQ);
    assign dma_addr = {page, PAGE_LO_W'(idx)};

    // DMA owns the OAM write port in WRITE; the CPU cannot compete because
    // dma_busy already locks OAM, but the DMA write is given priority anyway.
    // A restart arriving in WRITE still commits the byte already fetched.
    logic              oam_we;
    logic [OAM_AW-1:0] oam_waddr;
    logic [DATA_W-1:0] oam_wdata;

    always_comb begin
        oam_we    = oam_cpu_we;
        oam_waddr = oam_idx;
        oam_wdata = bus.cpu_wdata;
        if (state == WRITE) begin
            oam_we    = 1'b1;
            oam_waddr = idx;
            oam_wdata = data_q;
        end
    end

    // ---------------- Arrays ----------------
    vm_sp_ram #(
        .DEPTH (VRAM_SIZE),
        .WIDTH (DATA_W)
    ) u_vram (
        .clk     (clk),
        .rst     (rst),
        .we      (vram_cpu_we),
        .waddr   (vram_idx),
        .wdata   (bus.cpu_wdata),
        .a_re    (vram_a_re),
        .a_addr  (vram_idx),
        .a_rdata (vram_a_rdata),
        .b_re    (ppu_vram_re),
        .b_addr  (ppu_vram_addr),
        .b_rdata (ppu_vram_rdata)
    );

    vm_sp_ram #(
        .DEPTH (OAM_SIZE),
        .WIDTH (DATA_W)
    ) u_oam (
        .clk     (clk),
        .rst     (rst),
        .we      (oam_we),
        .waddr   (oam_waddr),
        .wdata   (oam_wdata),
        .a_re    (oam_a_re),
        .a_addr  (oam_idx),
        .a_rdata (oam_a_rdata),
        .b_re    (ppu_oam_re),
        .b_addr  (ppu_oam_addr),
        .b_rdata (ppu_oam_rdata)
    );
endmodule
